// File: rtl/sprite_fetcher_pkg.sv
// Shared sprite types: active-list entry layouts, fetch FSM states and pixel constants.
package sprite_fetcher_pkg;

  localparam int unsigned ADDR_W     = 18;
  localparam int unsigned LB_W       = 11;
  localparam int unsigned IDX_W      = 9;
  localparam int unsigned TC_W       = 13;
  localparam int unsigned TILE_PIX   = 16;
  localparam logic [3:0]  TRANSPARENT = 4'h0;

  typedef struct packed {
    logic              x_flip;
    logic [TC_W-1:0]   tile_count;
    logic [ADDR_W-1:0] tilemap_addr;
  } active_tilemap_addr_t;

  typedef struct packed {
    logic [2:0]        unused;
    logic [LB_W-1:0]   lb_addr;
    logic [ADDR_W-1:0] tile_bitmap_addr;
  } active_bitmap_addr_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INDEX,
    ST_LATCH,
    ST_TMAP_REQ,
    ST_TMAP_WAIT,
    ST_BMAP_REQ,
    ST_BMAP_WAIT,
    ST_DRAW,
    ST_DONE
  } fetch_state_t;

  // Flipped sprites walk their tilemap from the last tile backwards.
  function automatic logic [TC_W-1:0] tile_eff(input logic x_flip,
                                               input logic [TC_W-1:0] tile_count,
                                               input logic [TC_W-1:0] t);
    return x_flip ? TC_W'(tile_count - t) : t;
  endfunction

endpackage

// File: rtl/sprite_fetcher.sv
// Walks the per-line active sprite list, fetches tilemap/bitmap words and writes
// pixel-doubled pixels to the back line buffer. Optional stats: SPRITE_FETCH_STATS_EN.
module sprite_fetcher
  import sprite_fetcher_pkg::*;
(
  input  logic                 clk_draw,
  input  logic                 rst_draw,
  input  logic                 line,
  output logic [IDX_W-1:0]     sprite_index,
  input  logic                 valid,
  input  active_tilemap_addr_t tilemap_addr,
  input  active_bitmap_addr_t  bitmap_addr,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_ready,
  input  logic                 mem_rvalid,
  input  logic [31:0]          mem_rdata,
  output logic                 lb_we,
  output logic [LB_W-1:0]      lb_addr,
  output logic [7:0]           lb_data,
  output logic                 busy
`ifdef SPRITE_FETCH_STATS_EN
  ,
  output logic [15:0]          overrun_count,
  output logic [15:0]          last_cycles
`endif
);

  fetch_state_t      state_q, state_d;
  logic [IDX_W-1:0]  sprite_index_d;
  logic              mem_req_d, lb_we_d, busy_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [LB_W-1:0]   lb_addr_d;
  logic [7:0]        lb_data_d;
  logic              x_flip_q, x_flip_d;
  logic [TC_W-1:0]   tile_count_q, tile_count_d, t_q, t_d;
  logic [ADDR_W-1:0] tmap_base_q, tmap_base_d, bmap_base_q, bmap_base_d;
  logic [LB_W-1:0]   screen_x_q, screen_x_d;
  logic [3:0]        palette_q, palette_d, k_q, k_d, nib;
  logic [31:0]       pix_word_q, pix_word_d;
  logic              discard_q, discard_d;
  logic              accept, take;
  logic              unused_bits;

  assign unused_bits = ^bitmap_addr.unused;

  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      state_q      <= ST_IDLE;
      sprite_index <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      lb_we        <= 1'b0;
      lb_addr      <= '0;
      lb_data      <= '0;
      busy         <= 1'b0;
      x_flip_q     <= 1'b0;
      tile_count_q <= '0;
      t_q          <= '0;
      tmap_base_q  <= '0;
      bmap_base_q  <= '0;
      screen_x_q   <= '0;
      palette_q    <= '0;
      k_q          <= '0;
      pix_word_q   <= '0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sprite_index <= sprite_index_d;
      mem_req      <= mem_req_d;
      mem_addr     <= mem_addr_d;
      lb_we        <= lb_we_d;
      lb_addr      <= lb_addr_d;
      lb_data      <= lb_data_d;
      busy         <= busy_d;
      x_flip_q     <= x_flip_d;
      tile_count_q <= tile_count_d;
      t_q          <= t_d;
      tmap_base_q  <= tmap_base_d;
      bmap_base_q  <= bmap_base_d;
      screen_x_q   <= screen_x_d;
      palette_q    <= palette_d;
      k_q          <= k_d;
      pix_word_q   <= pix_word_d;
      discard_q    <= discard_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    sprite_index_d = sprite_index;
    mem_req_d      = mem_req;
    mem_addr_d     = mem_addr;
    lb_we_d        = 1'b0;
    lb_addr_d      = lb_addr;
    lb_data_d      = lb_data;
    x_flip_d       = x_flip_q;
    tile_count_d   = tile_count_q;
    t_d            = t_q;
    tmap_base_d    = tmap_base_q;
    bmap_base_d    = bmap_base_q;
    screen_x_d     = screen_x_q;
    palette_d      = palette_q;
    k_d            = k_q;
    pix_word_d     = pix_word_q;
    discard_d      = discard_q && !mem_rvalid;
    accept         = mem_req && mem_ready;
    take           = mem_rvalid && !discard_q;
    nib            = x_flip_q ? pix_word_q[31:28] : pix_word_q[3:0];

    case (state_q)
      ST_INDEX: state_d = ST_LATCH;
      ST_LATCH: begin
        if (!valid) begin
          state_d = ST_DONE;
        end else begin
          x_flip_d     = tilemap_addr.x_flip;
          tile_count_d = tilemap_addr.tile_count;
          tmap_base_d  = tilemap_addr.tilemap_addr;
          bmap_base_d  = bitmap_addr.tile_bitmap_addr;
          screen_x_d   = bitmap_addr.lb_addr;
          t_d          = '0;
          mem_addr_d   = tilemap_addr.tilemap_addr + ADDR_W'(tile_eff(tilemap_addr.x_flip,
                                                      tilemap_addr.tile_count, '0));
          // A stale read from an aborted walk must return before the next request.
          mem_req_d    = !discard_d;
          state_d      = ST_TMAP_REQ;
        end
      end
      ST_TMAP_REQ, ST_BMAP_REQ: begin
        if (accept) begin
          mem_req_d = 1'b0;
          state_d   = (state_q == ST_TMAP_REQ) ? ST_TMAP_WAIT : ST_BMAP_WAIT;
        end else if (!mem_req && !discard_q) begin
          mem_req_d = 1'b1;
        end
      end
      ST_TMAP_WAIT: begin
        if (take) begin
          palette_d  = mem_rdata[15:12];
          mem_addr_d = bmap_base_q + ADDR_W'(mem_rdata[8:0]);
          mem_req_d  = 1'b1;
          state_d    = ST_BMAP_REQ;
        end
      end
      ST_BMAP_WAIT: begin
        if (take) begin
          pix_word_d = mem_rdata;
          k_d        = '0;
          state_d    = ST_DRAW;
        end
      end
      ST_DRAW: begin
        // Each nibble covers two screen pixels; shift after the second.
        lb_we_d   = (nib != TRANSPARENT);
        lb_addr_d = screen_x_q + LB_W'({t_q, 4'b0000}) + LB_W'(k_q);
        lb_data_d = {palette_q, nib};
        k_d       = k_q + 4'd1;
        if (k_q[0]) begin
          pix_word_d = x_flip_q ? {pix_word_q[27:0], 4'h0} : {4'h0, pix_word_q[31:4]};
        end
        if (k_q == 4'(TILE_PIX - 1)) begin
          if (t_q != tile_count_q) begin
            t_d        = t_q + TC_W'(1);
            mem_addr_d = tmap_base_q + ADDR_W'(tile_eff(x_flip_q, tile_count_q,
                                                         t_q + TC_W'(1)));
            mem_req_d  = 1'b1;
            state_d    = ST_TMAP_REQ;
          end else if (sprite_index == {IDX_W{1'b1}}) begin
            state_d = ST_DONE;
          end else begin
            sprite_index_d = sprite_index + IDX_W'(1);
            state_d        = ST_INDEX;
          end
        end
      end
      default: ;
    endcase

    if (line) begin
      state_d        = ST_INDEX;
      sprite_index_d = '0;
      mem_req_d      = 1'b0;
      lb_we_d        = 1'b0;
      if (accept || (((state_q == ST_TMAP_WAIT) || (state_q == ST_BMAP_WAIT)) && !mem_rvalid))
        discard_d = 1'b1;
    end

    busy_d = !((state_d == ST_IDLE) || (state_d == ST_DONE));
  end

`ifdef SPRITE_FETCH_STATS_EN
  logic [15:0] cycle_cnt;

  // Per-line busy-cycle measurement and overrun tally.
  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      overrun_count <= '0;
      last_cycles   <= '0;
      cycle_cnt     <= '0;
    end else if (line) begin
      last_cycles <= cycle_cnt;
      cycle_cnt   <= '0;
      if (busy && (overrun_count != 16'hFFFF))
        overrun_count <= overrun_count + 16'd1;
    end else if (busy && (cycle_cnt != 16'hFFFF)) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_fetcher.sv
// Scoreboard bench for sprite_fetcher: reference model fills expected memory-address
// and line-buffer-write queues; monitors compare whenever the DUT issues them.
module tb_sprite_fetcher;
  import sprite_fetcher_pkg::*;

  logic                 clk_draw = 1'b0;
  logic                 rst_draw, line;
  logic [IDX_W-1:0]     sprite_index;
  logic                 valid;
  active_tilemap_addr_t tilemap_addr;
  active_bitmap_addr_t  bitmap_addr;
  logic                 mem_req, mem_ready, mem_rvalid;
  logic [ADDR_W-1:0]    mem_addr;
  logic [31:0]          mem_rdata;
  logic                 lb_we, busy;
  logic [LB_W-1:0]      lb_addr;
  logic [7:0]           lb_data;

  always #5 clk_draw = ~clk_draw;

  sprite_fetcher dut (
    .clk_draw(clk_draw), .rst_draw(rst_draw), .line(line), .sprite_index(sprite_index),
    .valid(valid), .tilemap_addr(tilemap_addr), .bitmap_addr(bitmap_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_addr(lb_addr),
    .lb_data(lb_data), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Active sprite list: registered read, one cycle after sprite_index.
  active_tilemap_addr_t tm_list [512];
  active_bitmap_addr_t  bm_list [512];
  int n_entries = 0;

  always @(posedge clk_draw) begin
    valid        <= (int'(sprite_index) < n_entries);
    tilemap_addr <= tm_list[sprite_index];
    bitmap_addr  <= bm_list[sprite_index];
  end

  logic [31:0] mem [int];

  function automatic logic [31:0] mem_rd(input int a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  logic [ADDR_W-1:0] exp_addr [$];
  logic [LB_W+7:0]   exp_px [$];

  // Reference: walk the list with plain arithmetic; full=0 stops after the first fetch pair.
  task automatic run_model(input bit full);
    for (int i = 0; i < n_entries && i < 512; i++) begin
      int ntiles;
      ntiles = int'(tm_list[i].tile_count) + 1;
      for (int j = 0; j < ntiles; j++) begin
        int te, ta, ba, sx;
        logic [31:0] tw, bw;
        te = tm_list[i].x_flip ? (ntiles - 1 - j) : j;
        ta = (int'(tm_list[i].tilemap_addr) + te) & ((1 << ADDR_W) - 1);
        tw = mem_rd(ta);
        ba = (int'(bm_list[i].tile_bitmap_addr) + int'(tw[8:0])) & ((1 << ADDR_W) - 1);
        bw = mem_rd(ba);
        exp_addr.push_back(ADDR_W'(ta));
        exp_addr.push_back(ADDR_W'(ba));
        if (!full) return;
        sx = int'(bm_list[i].lb_addr);
        for (int k = 0; k < 16; k++) begin
          int nidx, a;
          logic [3:0] nb;
          nidx = tm_list[i].x_flip ? 7 - k / 2 : k / 2;
          nb   = bw[4*nidx +: 4];
          a    = (sx + 16 * j + k) % (1 << LB_W);
          if (nb != 4'h0) exp_px.push_back({LB_W'(a), tw[15:12], nb});
        end
      end
    end
  endtask

  // Memory responder with random acceptance and latency.
  int ready_pct = 100, lat_min = 1, lat_max = 1, accepts = 0;
  bit pend, inflight;
  int pend_cnt;
  logic [31:0] pend_data;

  always @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      mem_ready  <= 1'b0;
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
      pend     = 1'b0;
      inflight = 1'b0;
    end else begin
      int lat;
      mem_rvalid <= 1'b0;
      if (mem_rvalid) inflight = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= pend_data;
          pend = 1'b0;
        end else pend_cnt--;
      end
      if (mem_req && mem_ready) begin
        accepts++;
        check("single_outstanding", 64'(inflight), 0);
        if (exp_addr.size() == 0) check("unexpected_req", {1'b1, mem_addr}, 0);
        else check("mem_addr", mem_addr, exp_addr.pop_front());
        pend_data = mem_rd(int'(mem_addr));
        inflight  = 1'b1;
        lat = $urandom_range(lat_max, lat_min);
        if (lat <= 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= pend_data;
        end else begin
          pend     = 1'b1;
          pend_cnt = lat - 2;
        end
      end
      mem_ready <= ($urandom_range(99, 0) < ready_pct);
    end
  end

  always @(negedge clk_draw) begin
    if (!rst_draw && lb_we) begin
      if (exp_px.size() == 0) check("unexpected_lb_write", {1'b1, lb_addr, lb_data}, 0);
      else check("lb_write", {lb_addr, lb_data}, exp_px.pop_front());
    end
  end

  task automatic set_sprite(input int i, input bit flip, input int tc, input int tmb,
                            input int sx, input int bmb);
    tm_list[i].x_flip           = flip;
    tm_list[i].tile_count       = TC_W'(tc);
    tm_list[i].tilemap_addr     = ADDR_W'(tmb);
    bm_list[i].unused           = '0;
    bm_list[i].lb_addr          = LB_W'(sx);
    bm_list[i].tile_bitmap_addr = ADDR_W'(bmb);
  endtask

  task automatic pulse_line();
    @(negedge clk_draw) line = 1'b1;
    @(negedge clk_draw) line = 1'b0;
  endtask

  task automatic finish_line(input string nm, input int budget);
    int c;
    c = 0;
    while (busy && c < budget) begin
      @(negedge clk_draw);
      c++;
    end
    check({nm, "_done"}, 64'(busy), 0);
    repeat (3) @(negedge clk_draw);
    check({nm, "_px_left"}, exp_px.size(), 0);
    check({nm, "_addr_left"}, exp_addr.size(), 0);
    exp_px.delete();
    exp_addr.delete();
  endtask

  task automatic run_line(input string nm, input int budget);
    run_model(1'b1);
    pulse_line();
    finish_line(nm, budget);
  endtask

  initial begin
    int c;
    rst_draw = 1'b1;
    line     = 1'b0;
    repeat (3) @(negedge clk_draw);
    check("rst_sprite_index", sprite_index, 0);
    check("rst_mem_req", 64'(mem_req), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_lb_we", 64'(lb_we), 0);
    check("rst_lb_addr", lb_addr, 0);
    check("rst_lb_data", lb_data, 0);
    check("rst_busy", 64'(busy), 0);
    rst_draw = 1'b0;
    repeat (2) @(negedge clk_draw);

    n_entries = 1;
    set_sprite(0, 1'b0, 0, 'h100, 100, 'h2000);
    mem['h100]  = 32'h0000_0005;
    mem['h2005] = 32'h7654_3210;
    run_line("plain", 200);

    set_sprite(0, 1'b1, 0, 'h100, 100, 'h2000);
    run_line("xflip", 200);

    set_sprite(0, 1'b1, 2, 'h300, 500, 'h4000);
    mem['h300] = 32'h0000_A011;
    mem['h301] = 32'h0000_B012;
    mem['h302] = 32'h0000_C013;
    run_line("flip_multi", 400);

    n_entries = 0;
    pulse_line();
    check("empty_busy_start", 64'(busy), 1);
    repeat (2) @(negedge clk_draw);
    check("empty_busy_low", 64'(busy), 0);
    check("empty_index", sprite_index, 0);
    finish_line("empty", 20);

    n_entries = 1;
    set_sprite(0, 1'b0, 0, 'h500, 2040, 'h6000);
    mem['h500]  = 32'h0000_3007;
    mem['h6007] = 32'h8765_4321;
    run_line("wrap", 200);

    set_sprite(0, 1'b0, 0, 'h700, 300, 'h7000);
    lat_min = 6;
    lat_max = 6;
    accepts = 0;
    run_model(1'b0);
    run_model(1'b1);
    pulse_line();
    c = 0;
    while (accepts < 2 && c < 100) begin
      @(negedge clk_draw);
      c++;
    end
    check("abort_reached_bmap", 64'(accepts >= 2), 1);
    line = 1'b1;
    @(negedge clk_draw) line = 1'b0;
    check("abort_index", sprite_index, 0);
    check("abort_no_req", 64'(mem_req), 0);
    finish_line("abort", 400);

    lat_min = 1;
    lat_max = 1;
    n_entries = 512;
    for (int i = 0; i < 512; i++) set_sprite(i, 1'b0, 0, 'h100, i, 'h2000);
    run_line("full_list", 20000);
    check("full_list_index", sprite_index, 511);

    ready_pct = 60;
    lat_min   = 1;
    lat_max   = 4;
    for (int r = 0; r < 6; r++) begin
      n_entries = $urandom_range(6, 1);
      for (int i = 0; i < n_entries; i++)
        set_sprite(i, 1'($urandom_range(1, 0)), $urandom_range(3, 0), int'($urandom),
                   int'($urandom), int'($urandom));
      run_line("random", 5000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
